multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
Control FSM for the multicycle RV32I datapath, built as the sequential counterpart of the single-cycle main decoder. It sequences one shared ALU and one unified instruction/data memory through fetch, decode, execute, memory and writeback steps. Every datapath enable and mux select is driven from the current state and the latched opcode. Memory accesses use a req/ready handshake, so variable-latency memory stalls the FSM.

Parameters:
- RESET_STATE, S_FETCH: state entered on reset.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- op  in  7  opcode field of the instruction register; valid from S_DECODE onward
- br_taken  in  1  branch comparator result for funct3, from the datapath
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- IRWrite  out  1  enable for the instruction register and OldPC
- MemWrite  out  1  store strobe
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result select: 00=ALUOut, 01=mem data, 10=ALUResult
- ALUSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1, 11=zero
- ALUSrcB  out  2  ALU B select: 00=rs2, 01=imm, 10=constant 4
- ALUop  out  2  to the ALU decoder: 00=add, 01=branch compare, 10=funct-decoded
- ImmSrc  out  3  immediate type: I=000, S=001, B=010, J=011, U=100
- illegal  out  1  sticky illegal-opcode flag

Behaviour:
- One-hot or binary encoding is allowed. All outputs are a registered state decoded combinationally (Moore), except the gating by mem_ready and br_taken noted below.
- Reset: state=S_FETCH, illegal=0. While reset is high, every enable output is 0 and every select output is 0. Reset mid-instruction abandons the instruction; no write strobe is asserted in the reset cycle.
- Default in every state: all enables=0, all selects=00, ALUop=00.
- ImmSrc is decoded from op in every state. Unknown op gives 000.
- S_FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10. IRWrite and PCWrite are asserted only when mem_ready=1, and the FSM goes to S_DECODE. Otherwise it holds with mem_req=1.
- S_DECODE: ALUSrcA=01, ALUSrcB=01 (branch/JAL target into ALUOut). Next state by op:
  - lw to S_MEMADR
  - sw to S_MEMADR
  - R-type to S_EXER
  - I-ALU to S_EXEI
  - branch to S_BRANCH
  - jal to S_JAL
  - jalr to S_JALR
  - lui to S_LUI
  - auipc to S_ALUWB
  - 0000000 to S_FETCH (NOP)
  - any other op to S_TRAP
- S_MEMADR: ALUSrcA=10, ALUSrcB=01. lw goes to S_MEMRD; sw goes to S_MEMWR.
- S_MEMRD: mem_req=1, AdrSrc=1. Holds until mem_ready, then goes to S_MEMWB.
- S_MEMWB: ResultSrc=01, RegWrite=1, then S_FETCH.
- S_MEMWR: mem_req=1, AdrSrc=1, MemWrite=1. Holds until mem_ready, then S_FETCH. MemWrite stays high for the whole hold.
- S_EXER: ALUSrcA=10, ALUSrcB=00, ALUop=10, then S_ALUWB.
- S_EXEI: ALUSrcA=10, ALUSrcB=01, ALUop=10, then S_ALUWB.
- S_LUI: ALUSrcA=11, ALUSrcB=01, then S_ALUWB.
- S_ALUWB: ResultSrc=00, RegWrite=1, then S_FETCH.
- S_BRANCH: ALUSrcA=10, ALUSrcB=00, ALUop=01, ResultSrc=00. PCWrite=br_taken. Then S_FETCH.
- S_JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1, then S_ALUWB (link = OldPC+4).
- S_JALR: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, PCWrite=1, then S_LINK.
- S_LINK: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, RegWrite=1, then S_FETCH.
- S_TRAP: illegal=1, all enables=0. Stays in S_TRAP until reset.
- Cycle counts with zero memory wait states:
  - lw: 5
  - sw: 4
  - R-type and I-ALU: 4
  - branch: 3
  - jal: 4
  - jalr: 4
  - lui: 4
  - auipc: 3
  - Each memory wait cycle adds 1.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- When defined, adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both reset to 0.
  - cycle_cnt increments every non-reset cycle.
  - instret_cnt increments on the final state of each instruction. S_TRAP does not count.
  - Both counters wrap at 2^32 with no sticky saturation.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Decomposition:
- Package mc_pkg holds:
  - state enum
  - ALUSrcA/ALUSrcB/ResultSrc/ImmSrc/ALUop encodings
  - opcode constants
- Sub-module mc_imm_decode: combinational op-to-ImmSrc, reused by the pipeline decoder.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 -> state S_FETCH, all enables 0 during reset, IRWrite=PCWrite=1 in the first cycle after release.
- lw (op=0000011), mem_ready=1 always -> exactly 5 cycles; RegWrite=1 with ResultSrc=01 only in cycle 5.
- sw (op=0100011) with mem_ready low for 3 cycles in S_MEMWR -> MemWrite=1 and AdrSrc=1 for 4 cycles, then S_FETCH; total 7 cycles.
- beq (op=1100011), br_taken=0 then repeat with br_taken=1 -> 3 cycles each; PCWrite=0 then 1 in S_BRANCH.
- jalr (op=1100111) -> S_JALR has PCWrite=1, ResultSrc=10; S_LINK has RegWrite=1, ALUSrcA=01, ALUSrcB=10; total 4 cycles.
- op=1111111 -> illegal=1 from the cycle after S_DECODE, held with no enables for 10+ cycles; reset clears it.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
package mc_pkg;

    localparam int unsigned OP_W  = 7;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned IMM_W = 3;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXER,
        S_EXEI,
        S_LUI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LINK,
        S_TRAP
    } state_e;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;
    localparam logic [SEL_W-1:0] SRCA_ZERO  = 2'b11;

    localparam logic [SEL_W-1:0] SRCB_RS2   = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

    localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] RES_MEM    = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURES = 2'b10;

    localparam logic [SEL_W-1:0] ALUOP_ADD  = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_BR   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNC = 2'b10;

    localparam logic [IMM_W-1:0] IMM_I = 3'b000;
    localparam logic [IMM_W-1:0] IMM_S = 3'b001;
    localparam logic [IMM_W-1:0] IMM_B = 3'b010;
    localparam logic [IMM_W-1:0] IMM_J = 3'b011;
    localparam logic [IMM_W-1:0] IMM_U = 3'b100;

    localparam logic [OP_W-1:0] OP_LW    = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW    = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R     = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I     = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BR    = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR  = 7'b1100111;
    localparam logic [OP_W-1:0] OP_LUI   = 7'b0110111;
    localparam logic [OP_W-1:0] OP_AUIPC = 7'b0010111;
    localparam logic [OP_W-1:0] OP_NOP   = 7'b0000000;

    typedef struct packed {
        logic             mem_req;
        logic             pc_write;
        logic             adr_src;
        logic             ir_write;
        logic             mem_write;
        logic             reg_write;
        logic [SEL_W-1:0] result_src;
        logic [SEL_W-1:0] alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/mc_imm_decode.sv
// Opcode to immediate-type decode; shared with the pipeline decoder.
module mc_imm_decode
    import mc_pkg::*;
(
    input  logic [OP_W-1:0]  op_i,
    output logic [IMM_W-1:0] imm_src_o
);

    always_comb begin
        imm_src_o = IMM_I;
        case (op_i)
            OP_SW:             imm_src_o = IMM_S;
            OP_BR:             imm_src_o = IMM_B;
            OP_JAL:            imm_src_o = IMM_J;
            OP_LUI, OP_AUIPC:  imm_src_o = IMM_U;
            default:           imm_src_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I datapath with req/ready memory.
// Optional perf counters (cycle_cnt, instret_cnt) under MC_PERF_CNT_EN.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter state_e RESET_STATE = S_FETCH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  op,
    input  logic             br_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [SEL_W-1:0] ResultSrc,
    output logic [SEL_W-1:0] ALUSrcA,
    output logic [SEL_W-1:0] ALUSrcB,
    output logic [SEL_W-1:0] ALUop,
    output logic [IMM_W-1:0] ImmSrc,
    output logic             illegal
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]      cycle_cnt,
    output logic [31:0]      instret_cnt
`endif
);

    state_e           state_q, state_d;
    ctrl_t            ctrl_c;
    logic [IMM_W-1:0] imm_c;

    mc_imm_decode u_imm_decode (
        .op_i      (op),
        .imm_src_o (imm_c)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= RESET_STATE;
        else       state_q <= state_d;
    end

    // Next state and control decode; reset forces every control to zero.
    always_comb begin
        state_d = state_q;
        ctrl_c  = '0;
        case (state_q)
            S_FETCH: begin
                ctrl_c.mem_req    = 1'b1;
                ctrl_c.alu_src_a  = SRCA_PC;
                ctrl_c.alu_src_b  = SRCB_FOUR;
                ctrl_c.result_src = RES_ALURES;
                if (mem_ready) begin
                    ctrl_c.ir_write = 1'b1;
                    ctrl_c.pc_write = 1'b1;
                    state_d         = S_DECODE;
                end
            end
            S_DECODE: begin
                ctrl_c.alu_src_a = SRCA_OLDPC;
                ctrl_c.alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXER;
                    OP_I:         state_d = S_EXEI;
                    OP_BR:        state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALR;
                    OP_LUI:       state_d = S_LUI;
                    OP_AUIPC:     state_d = S_ALUWB;
                    OP_NOP:       state_d = S_FETCH;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ctrl_c.alu_src_a = SRCA_RS1;
                ctrl_c.alu_src_b = SRCB_IMM;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctrl_c.mem_req = 1'b1;
                ctrl_c.adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl_c.result_src = RES_MEM;
                ctrl_c.reg_write  = 1'b1;
                state_d           = S_FETCH;
            end
            S_MEMWR: begin
                ctrl_c.mem_req   = 1'b1;
                ctrl_c.adr_src   = 1'b1;
                ctrl_c.mem_write = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXER: begin
                ctrl_c.alu_src_a = SRCA_RS1;
                ctrl_c.alu_src_b = SRCB_RS2;
                ctrl_c.alu_op    = ALUOP_FUNC;
                state_d          = S_ALUWB;
            end
            S_EXEI: begin
                ctrl_c.alu_src_a = SRCA_RS1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALUOP_FUNC;
                state_d          = S_ALUWB;
            end
            S_LUI: begin
                ctrl_c.alu_src_a = SRCA_ZERO;
                ctrl_c.alu_src_b = SRCB_IMM;
                state_d          = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl_c.result_src = RES_ALUOUT;
                ctrl_c.reg_write  = 1'b1;
                state_d           = S_FETCH;
            end
            S_BRANCH: begin
                ctrl_c.alu_src_a  = SRCA_RS1;
                ctrl_c.alu_src_b  = SRCB_RS2;
                ctrl_c.alu_op     = ALUOP_BR;
                ctrl_c.result_src = RES_ALUOUT;
                ctrl_c.pc_write   = br_taken;
                state_d           = S_FETCH;
            end
            S_JAL: begin
                // ALUOut already holds the target from decode; compute the link.
                ctrl_c.alu_src_a  = SRCA_OLDPC;
                ctrl_c.alu_src_b  = SRCB_FOUR;
                ctrl_c.result_src = RES_ALUOUT;
                ctrl_c.pc_write   = 1'b1;
                state_d           = S_ALUWB;
            end
            S_JALR: begin
                ctrl_c.alu_src_a  = SRCA_RS1;
                ctrl_c.alu_src_b  = SRCB_IMM;
                ctrl_c.result_src = RES_ALURES;
                ctrl_c.pc_write   = 1'b1;
                state_d           = S_LINK;
            end
            S_LINK: begin
                ctrl_c.alu_src_a  = SRCA_OLDPC;
                ctrl_c.alu_src_b  = SRCB_FOUR;
                ctrl_c.result_src = RES_ALURES;
                ctrl_c.reg_write  = 1'b1;
                state_d           = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = RESET_STATE;
        endcase
        if (reset) ctrl_c = '0;
    end

    assign mem_req   = ctrl_c.mem_req;
    assign PCWrite   = ctrl_c.pc_write;
    assign AdrSrc    = ctrl_c.adr_src;
    assign IRWrite   = ctrl_c.ir_write;
    assign MemWrite  = ctrl_c.mem_write;
    assign RegWrite  = ctrl_c.reg_write;
    assign ResultSrc = ctrl_c.result_src;
    assign ALUSrcA   = ctrl_c.alu_src_a;
    assign ALUSrcB   = ctrl_c.alu_src_b;
    assign ALUop     = ctrl_c.alu_op;
    assign ImmSrc    = reset ? IMM_W'(0) : imm_c;
    assign illegal   = !reset && (state_q == S_TRAP);

`ifdef MC_PERF_CNT_EN
    localparam int unsigned CNT_W = 32;

    logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;
    logic             retire_c;

    // Final state of each instruction; a trapped opcode never retires.
    always_comb begin
        retire_c = 1'b0;
        case (state_q)
            S_MEMWB, S_ALUWB, S_BRANCH, S_LINK: retire_c = 1'b1;
            S_MEMWR:  retire_c = mem_ready;
            S_DECODE: retire_c = (op == OP_NOP);
            default:  retire_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            if (retire_c) instret_cnt_q <= instret_cnt_q + CNT_W'(1);
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule
